// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
//   Shared definitions for the instruction-fetch sequencer: FSM state
//   encoding, vector-loader phase encoding, address width, default reset PC
//   and interrupt-vector location, the reserved low-memory region size and
//   the PC increment helper.
package fetch_ctrl_pkg;

  localparam int ADDR_W = 20;

  // Low region of instruction memory reserved for vectors; code starts after it.
  localparam int RSVD_SIZE = 32'h20;

  localparam logic [31:0]       RESET_PC_DEF     = 32'h0000_0020;
  localparam logic [ADDR_W-1:0] INT_VEC_ADDR_DEF = 20'h00000;
  // Reset vector (used only when the reset-vector feature is built in).
  localparam logic [ADDR_W-1:0] RST_VEC_ADDR     = 20'h00002;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_VEC_HI = 3'd1,
    ST_VEC_LO = 3'd2,
    ST_RST_HI = 3'd3,
    ST_RST_LO = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_HI   = 2'd1,
    LD_LO   = 2'd2
  } ld_phase_e;

  // Sequential PC step; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_ctrl_vec_loader.sv
// fetch_ctrl_vec_loader
//   Two-cycle capture of a 20-bit vector stored as two 16-bit words:
//   the hi word at addr_base (only bits [3:0] are kept) and the lo word at
//   addr_base+1. A start pulse latches addr_base; the next cycle presents
//   the hi address (HI phase), the cycle after presents the lo address (LO
//   phase), during which done is high and vec = {hi[3:0], instr_in}.
//   Parameters RESET_START/RESET_BASE let reset launch a load directly.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           begin a load next cycle
//   i_addr_base       word address of the hi half (latched on i_start)
//   i_instr_in        instruction-memory read data for o_addr
//   o_addr            read address while loading
//   o_done            high in the LO phase; o_vec is valid then
//   o_vec             assembled 20-bit vector
//   o_dbg_phase       current loader phase
module fetch_ctrl_vec_loader
  import fetch_ctrl_pkg::*;
#(
  parameter bit                RESET_START = 1'b0,
  parameter logic [ADDR_W-1:0] RESET_BASE  = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr_base,
  input  logic [15:0]       i_instr_in,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_vec,
  output logic [1:0]        o_dbg_phase
);

  ld_phase_e         r_phase;
  ld_phase_e         w_phase_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [3:0]        r_hi;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase <= RESET_START ? LD_HI : LD_IDLE;
      r_base  <= RESET_BASE;
      r_hi    <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      if (i_start) r_base <= i_addr_base;
      if (r_phase == LD_HI) r_hi <= i_instr_in[3:0];
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    case (r_phase)
      LD_IDLE: if (i_start) w_phase_nxt = LD_HI;
      LD_HI:   w_phase_nxt = LD_LO;
      LD_LO:   w_phase_nxt = i_start ? LD_HI : LD_IDLE;
      default: w_phase_nxt = LD_IDLE;
    endcase
  end

  always_comb begin
    case (r_phase)
      LD_HI:   o_addr = r_base;
      LD_LO:   o_addr = r_base + ADDR_W'(1);
      default: o_addr = i_addr_base;
    endcase
  end

  assign o_done      = (r_phase == LD_LO);
  assign o_vec       = {r_hi, i_instr_in};
  assign o_dbg_phase = r_phase;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Instruction-fetch sequencer. Owns the 20-bit PC and drives the
//   instruction-memory read address. In RUN the next PC is chosen with
//   priority branch > interrupt > stall > increment. An accepted interrupt
//   saves the PC, pulses o_int_ack, then spends VEC_HI/VEC_LO reading a
//   two-word vector from INT_VEC_ADDR/+1 through the vector loader.
//
//   Handshake: o_fetch_valid qualifies i_instr_in for decode in the same
//   cycle. There is no ready; decode back-pressure is expressed through
//   i_stall, which holds the PC so the same fetch is re-presented with
//   o_fetch_valid still high.
//
//   Build option FETCH_CTRL_RESET_VEC_EN: when defined, reset enters
//   RST_HI/RST_LO and loads the PC from words 0x00002/0x00003 (RESET_PC is
//   then unused). When undefined, reset loads RESET_PC directly.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_stall               hold PC
//   i_br_taken            redirect this cycle
//   i_br_target           redirect target (bits above ADDR_W ignored)
//   i_int_req             level interrupt request
//   i_instr_in            imem read data (combinational read of o_imem_addr)
//   o_imem_addr           imem read address
//   o_pc                  address of the presented instruction
//   o_fetch_valid         i_instr_in is a real instruction
//   o_int_ack             one-cycle pulse on interrupt accept
//   o_saved_pc            PC of the first unfetched instruction at accept
//   o_dbg_state           current FSM state (state_e encoding)
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0]       RESET_PC     = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] INT_VEC_ADDR = INT_VEC_ADDR_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_br_taken,
  input  logic [31:0]       i_br_target,
  input  logic              i_int_req,
  input  logic [15:0]       i_instr_in,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_pc,
  output logic              o_fetch_valid,
  output logic              o_int_ack,
  output logic [31:0]       o_saved_pc,
  output logic [2:0]        o_dbg_state
);

`ifdef FETCH_CTRL_RESET_VEC_EN
  localparam state_e            RST_STATE    = ST_RST_HI;
  localparam bit                LD_RST_START = 1'b1;
  localparam logic [ADDR_W-1:0] RST_PC_LOW   = '0;
`else
  localparam state_e            RST_STATE    = ST_RUN;
  localparam bit                LD_RST_START = 1'b0;
  localparam logic [ADDR_W-1:0] RST_PC_LOW   = RESET_PC[ADDR_W-1:0];
`endif

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_saved_pc;
  logic              w_save;
  logic              w_start;
  logic              w_fetch_valid;
  logic              w_int_ack;
  logic [ADDR_W-1:0] w_ld_addr;
  logic              w_ld_done;
  logic [ADDR_W-1:0] w_ld_vec;
  logic [1:0]        w_unused_ld_phase;
  logic              w_unused_ok;

  // Target bits above the implemented PC width are ignored by design.
  assign w_unused_ok = &{1'b0, i_br_target[31:ADDR_W], w_unused_ld_phase};

  fetch_ctrl_vec_loader #(
    .RESET_START (LD_RST_START),
    .RESET_BASE  (RST_VEC_ADDR)
  ) u_vec_loader (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (w_start),
    .i_addr_base (INT_VEC_ADDR),
    .i_instr_in  (i_instr_in),
    .o_addr      (w_ld_addr),
    .o_done      (w_ld_done),
    .o_vec       (w_ld_vec),
    .o_dbg_phase (w_unused_ld_phase)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= RST_STATE;
      r_pc       <= RST_PC_LOW;
      r_saved_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_save) r_saved_pc <= r_pc;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_fetch_valid = 1'b0;
    w_int_ack     = 1'b0;
    w_save        = 1'b0;
    w_start       = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_fetch_valid = 1'b1;
        if (i_br_taken) begin
          // Branch wins even over stall; a pending interrupt waits a cycle.
          w_pc_nxt = i_br_target[ADDR_W-1:0];
        end else if (i_int_req) begin
          // The instruction on the bus now is dropped and refetched on return.
          w_int_ack     = 1'b1;
          w_fetch_valid = 1'b0;
          w_save        = 1'b1;
          w_start       = 1'b1;
          w_state_nxt   = ST_VEC_HI;
        end else if (!i_stall) begin
          w_pc_nxt = pc_inc(r_pc);
        end
      end
      ST_VEC_HI: w_state_nxt = ST_VEC_LO;
      ST_RST_HI: w_state_nxt = ST_RST_LO;
      ST_VEC_LO, ST_RST_LO: begin
        if (w_ld_done) begin
          w_pc_nxt    = w_ld_vec;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign o_imem_addr   = (r_state == ST_RUN) ? r_pc : w_ld_addr;
  assign o_pc          = {{(32-ADDR_W){1'b0}}, r_pc};
  assign o_saved_pc    = {{(32-ADDR_W){1'b0}}, r_saved_pc};
  assign o_fetch_valid = w_fetch_valid;
  assign o_int_ack     = w_int_ack;
  assign o_dbg_state   = r_state;

endmodule
